// File: rtl/neureka_accumulator_streamout_pkg.sv
// Shared types and constants for the accumulator stream-out engine.
package neureka_package;

    // Drain sequencer states
    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        CLR,
        FIN
    } streamout_state_e;

    // The buffer's wide-read port addresses aligned groups with even codes:
    // group b is selected by address b*WIDE_ADDR_STEP.
    localparam int WIDE_ADDR_STEP = 2;

endpackage

// File: rtl/neureka_streamout_outreg.sv
// Single-entry output register of the stream-out path: loads a wide beat
// from the buffer, masks the unused words of a partial last beat, and holds
// it stable until the downstream handshake.
module neureka_streamout_outreg
    import neureka_package::*;
#(
    parameter int  DATA_WIDTH   = 32,
    parameter int  WIDTH_FACTOR = 8,
    localparam int REM_WIDTH    = $clog2(WIDTH_FACTOR)
) (
    input  logic                               clk_word,
    input  logic                               rst_ni,
    input  logic                               flush,
    input  logic                               load,
    input  logic [WIDTH_FACTOR*DATA_WIDTH-1:0] rdata_wide,
    input  logic                               last_beat,
    input  logic [REM_WIDTH-1:0]               rem,
    output logic                               free,
    output logic [WIDTH_FACTOR*DATA_WIDTH-1:0] data,
    output logic [WIDTH_FACTOR-1:0]            strb,
    output logic                               last,
    output logic                               valid,
    input  logic                               ready
);

    logic [WIDTH_FACTOR-1:0]            strb_d;
    logic [WIDTH_FACTOR*DATA_WIDTH-1:0] data_d;

    // The register can take a new beat when empty or being drained this cycle
    assign free = !valid || ready;

    // Per-word strobe: a partial last beat keeps only its low rem words,
    // and every word without a strobe is driven as zero.
    for (genvar w = 0; w < WIDTH_FACTOR; w++) begin : g_word
        assign strb_d[w] = !last_beat || (rem == '0) || (REM_WIDTH'(w) < rem);
        assign data_d[w*DATA_WIDTH +: DATA_WIDTH] =
            strb_d[w] ? rdata_wide[w*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    // Load/accept state of the single entry
    always_ff @(posedge clk_word or negedge rst_ni) begin
        if (!rst_ni) begin
            data  <= '0;
            strb  <= '0;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (flush) begin
            data  <= '0;
            strb  <= '0;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= data_d;
            strb  <= strb_d;
            last  <= last_beat;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/neureka_accumulator_streamout.sv
// Read-side engine of the accumulator buffer: drains up to NUM_WORDS words
// as WIDTH_FACTOR-word beats onto a valid/ready stream, optionally clearing
// the buffer once the final beat has been accepted.
module neureka_accumulator_streamout
    import neureka_package::*;
#(
    parameter int  DATA_WIDTH   = 32,
    parameter int  NUM_WORDS    = 32,
    parameter int  WIDTH_FACTOR = 8,
    localparam int ADDR_WIDTH   = $clog2(NUM_WORDS),
    localparam int NBEATS       = NUM_WORDS / WIDTH_FACTOR
) (
    input  logic                               clk_word,
    input  logic                               rst_ni,
    input  logic                               clear_i,
    input  logic                               start_i,
    input  logic [ADDR_WIDTH:0]                num_words_i,
    input  logic                               clear_on_done_i,
    output logic [ADDR_WIDTH-1:0]              raddr_o,
    input  logic [WIDTH_FACTOR*DATA_WIDTH-1:0] rdata_wide_i,
    output logic                               buf_clear_o,
    output logic [WIDTH_FACTOR*DATA_WIDTH-1:0] data_o,
    output logic [WIDTH_FACTOR-1:0]            strb_o,
    output logic                               last_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam int                BCW         = $clog2(NBEATS) + 1;
    localparam int                REM_WIDTH   = $clog2(WIDTH_FACTOR);
    localparam logic [ADDR_WIDTH:0] NUM_WORDS_L = (ADDR_WIDTH+1)'(NUM_WORDS);

    streamout_state_e       state_q;
    logic [BCW-1:0]         b_q;
    logic [BCW-1:0]         last_b_q;
    logic [REM_WIDTH-1:0]   rem_q;
    logic                   clr_pending_q;

    logic [ADDR_WIDTH:0]    n_sat;
    logic [ADDR_WIDTH:0]    nbeats_d;
    logic                   is_last;
    logic                   free;
    logic                   load;

    // Oversized requests drain the whole buffer
    assign n_sat = (num_words_i > NUM_WORDS_L) ? NUM_WORDS_L : num_words_i;

    // ceil(n / WIDTH_FACTOR); WIDTH_FACTOR is a power of two
    assign nbeats_d = (n_sat >> REM_WIDTH) +
                      {{ADDR_WIDTH{1'b0}}, |n_sat[REM_WIDTH-1:0]};

    assign is_last = (b_q == last_b_q);
    assign load    = (state_q == RUN) && free;

    // Wide-read address follows the beat counter only while reading
    assign raddr_o = (state_q == RUN) ?
                     ADDR_WIDTH'(b_q) * ADDR_WIDTH'(WIDE_ADDR_STEP) : '0;

    neureka_streamout_outreg #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WIDTH_FACTOR(WIDTH_FACTOR)
    ) i_outreg (
        .clk_word  (clk_word),
        .rst_ni    (rst_ni),
        .flush     (clear_i),
        .load      (load),
        .rdata_wide(rdata_wide_i),
        .last_beat (is_last),
        .rem       (rem_q),
        .free      (free),
        .data      (data_o),
        .strb      (strb_o),
        .last      (last_o),
        .valid     (valid_o),
        .ready     (ready_i)
    );

    // Drain sequencer with registered busy/done/clear outputs.
    // A drain that handed out beats pulses done_o on entry to FIN; an empty
    // drain enters FIN still busy and pulses done_o on the FIN exit, so busy_o
    // is visible for one cycle in that case too.
    always_ff @(posedge clk_word or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            b_q           <= '0;
            last_b_q      <= '0;
            rem_q         <= '0;
            clr_pending_q <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            buf_clear_o   <= 1'b0;
        end else if (clear_i) begin
            state_q       <= IDLE;
            b_q           <= '0;
            clr_pending_q <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            buf_clear_o   <= 1'b0;
        end else begin
            done_o      <= 1'b0;
            buf_clear_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        clr_pending_q <= clear_on_done_i;
                        last_b_q      <= BCW'(nbeats_d - (ADDR_WIDTH+1)'(1));
                        rem_q         <= n_sat[REM_WIDTH-1:0];
                        b_q           <= '0;
                        busy_o        <= 1'b1;
                        state_q       <= (n_sat == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    if (load) begin
                        b_q <= b_q + BCW'(1);
                        if (is_last) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (valid_o && ready_i) begin
                        if (clr_pending_q) begin
                            state_q     <= CLR;
                            buf_clear_o <= 1'b1;
                        end else begin
                            state_q <= FIN;
                            done_o  <= 1'b1;
                            busy_o  <= 1'b0;
                        end
                    end
                end
                CLR: begin
                    state_q <= FIN;
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                    done_o  <= !done_o;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/neureka_accumulator_streamout.md
Name: neureka_accumulator_streamout

Overview:
Read-side engine for the accumulator buffer. On a start pulse it reads the buffer in WIDTH_FACTOR-word beats over the buffer's wide read port and emits them as a valid/ready stream toward the output streamer. It masks the partial last beat and can optionally clear the buffer after the final beat is accepted. It sits between the accumulator buffer and the streamout/quantization path.

Parameters:
DATA_WIDTH, 32, width of one accumulator word
NUM_WORDS, 32, words in the accumulator buffer; must be a multiple of WIDTH_FACTOR
WIDTH_FACTOR, 8, words per wide beat
ADDR_WIDTH, $clog2(NUM_WORDS), localparam, buffer address width
NBEATS, NUM_WORDS/WIDTH_FACTOR, localparam, maximum beats per drain

Ports:
clk_word  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft abort; returns to IDLE
start_i  in  1  single-cycle drain request, sampled only in IDLE
num_words_i  in  ADDR_WIDTH+1  number of words to drain, 0..NUM_WORDS; sampled with start_i
clear_on_done_i  in  1  request a buffer clear after the last beat; sampled with start_i
raddr_o  out  ADDR_WIDTH  wide-read address to the buffer
rdata_wide_i  in  WIDTH_FACTOR*DATA_WIDTH  combinational wide read data from the buffer
buf_clear_o  out  1  one-cycle clear pulse to the buffer
data_o  out  WIDTH_FACTOR*DATA_WIDTH  stream data; word 0 in the LSBs
strb_o  out  WIDTH_FACTOR  per-word valid flags
last_o  out  1  marks the final beat
valid_o  out  1  stream valid
ready_i  in  1  stream ready
busy_o  out  1  high from accepted start until return to IDLE
done_o  out  1  one-cycle pulse at completion

Behaviour:
- Reset and clocking: reset is rst_ni, asynchronous, active-low; the clock is clk_word. All outputs reset to 0; FSM resets to IDLE.
- States:
  - IDLE: start_i=1 latches num_words_i and clear_on_done_i, zeroes beat counter b, sets busy_o=1.
    - num_words_i=0 goes straight to FIN.
    - Otherwise goes to RUN.
  - RUN: raddr_o = 2*b. The buffer's wide-read encoding uses even codes to select the aligned WIDTH_FACTOR-word group b.
    - The output register loads rdata_wide_i when it is empty or accepted this cycle (valid_o & ready_i). This gives 1 beat/cycle under continuous ready.
    - On load: b increments and valid_o=1.
    - strb_o is all-ones, except on the last beat, which uses the low (n mod WIDTH_FACTOR) bits when that remainder is nonzero.
    - data_o words with strb=0 are forced to zero.
    - last_o=1 on beat ceil(n/WIDTH_FACTOR)-1.
    - After the last load, the FSM goes to DRAIN.
  - DRAIN: hold data_o/strb_o/last_o/valid_o stable until ready_i.
    - On the handshake, go to CLR if the latched clear flag is set, else FIN.
  - CLR: buf_clear_o=1 for exactly one cycle, then FIN.
  - FIN: done_o=1 for one cycle, busy_o drops, then IDLE.
- Handshake: once valid_o=1, data_o/strb_o/last_o must not change and valid_o must not drop until ready_i=1 (AXI-stream rule). ready_i may toggle arbitrarily.
- raddr_o is held at 0 outside RUN. In RUN it changes only when a beat loads.
- start_i outside IDLE is ignored, including in the FIN cycle.
- clear_i has priority over everything:
  - next cycle: IDLE, valid_o=0, busy_o=0;
  - no done_o and no buf_clear_o are issued.
- num_words_i > NUM_WORDS saturates to NUM_WORDS.
- Beat counter width is $clog2(NBEATS)+1. There is no wrap-around within a drain.
- Latency:
  - start to first valid_o: 2 cycles (IDLE→RUN, load).
  - last handshake to done_o: 1 cycle, or 2 with clear.
- Reset mid-operation aborts immediately; the buffer contents are not touched.

Decomposition:
- Shared package neureka_package: state enum streamout_state_e {IDLE, RUN, DRAIN, CLR, FIN}, and constants for the even-code wide-address encoding (WIDE_ADDR_STEP = 2).
- One natural sub-module, neureka_streamout_outreg: the single-entry output register with load/accept logic and strobe masking. The FSM stays in the top module.

Test Plan:
- Full drain: num_words=32, ready_i=1, buffer word k = k. Expect:
  - 4 consecutive beats, raddr_o 0,2,4,6;
  - beat 0 holds words 0..7 with strb=8'hFF;
  - last_o only on beat 3;
  - done_o 1 cycle after beat 3.
- Partial drain: num_words=13. Expect 2 beats:
  - beat 1 strb=8'h1F;
  - words 13..15 zero in data_o;
  - last_o=1 on beat 1.
- Backpressure: num_words=32, ready_i toggling 1,0,0,1,0,1… Expect data_o/valid_o stable while ready_i=0, no beat lost or duplicated, and 4 handshakes total.
- Clear-on-done: clear_on_done_i=1, num_words=8. Expect buf_clear_o=1 exactly one cycle after the single handshake, then done_o the next cycle.
- Zero words: num_words=0. Expect no valid_o, done_o 2 cycles after start_i, busy_o high for 1 cycle.
- Abort: clear_i asserted while beat 1 is pending with ready_i=0. Expect next cycle valid_o=0 and busy_o=0, no done_o, and a new start accepted afterward with raddr_o restarting at 0.
